// File: rtl/tl_ul_sram_responder.sv
// TL-UL single-beat responder backed by a small flop-based SRAM.
// One response register; a new request can be accepted in the same cycle
// the pending response is taken, which gives one transfer per clock.
module tl_ul_sram_responder #(
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter int unsigned DEPTH     = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [1:0]  a_size,
    input  logic [2:0]  a_source,
    input  logic [29:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [1:0]  d_size,
    output logic [2:0]  d_source,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt,
    output logic [7:0]  err_count
);

    logic [31:0] mem [DEPTH];
    logic [3:0]  idx;
    logic        a_hs;
    logic        hit;
    logic        is_get;
    logic        is_put;
    logic        legal;
    logic [2:0]  rsp_opcode;
    logic        rsp_denied;
    logic [31:0] rsp_data;
    logic        rsp_corrupt;

    // Byte offset bits and a_param carry no meaning for a word-wide responder.
    logic unused_fields;
    assign unused_fields = ^{a_param, a_address[1:0]};

    assign idx     = a_address[5:2];
    assign a_ready = !d_valid || d_ready;
    assign a_hs    = a_valid && a_ready;
    assign hit     = (a_address[29:6] == BASE_ADDR) && (a_size != 2'd3);
    assign is_get  = (a_opcode == 3'd4);
    assign is_put  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    assign legal   = hit && (is_get || (is_put && !a_corrupt));
    assign d_param = 2'b00;

    // Decode the response for the request currently on the A channel.
    always_comb begin
        rsp_opcode  = {2'b00, is_get};
        rsp_denied  = !legal;
        rsp_data    = 32'h0;
        rsp_corrupt = !legal && is_get;
        if (legal && is_get) begin
            rsp_data = mem[idx];
        end
    end

    // Response register: load on A handshake, drop valid once D is taken.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_valid   <= 1'b0;
            d_opcode  <= 3'd0;
            d_size    <= 2'd0;
            d_source  <= 3'd0;
            d_denied  <= 1'b0;
            d_data    <= 32'h0;
            d_corrupt <= 1'b0;
        end else if (a_hs) begin
            d_valid   <= 1'b1;
            d_opcode  <= rsp_opcode;
            d_size    <= a_size;
            d_source  <= a_source;
            d_denied  <= rsp_denied;
            d_data    <= rsp_data;
            d_corrupt <= rsp_corrupt;
        end else if (d_ready) begin
            d_valid   <= 1'b0;
        end
    end

    // Storage array; byte-masked writes for legal Put requests.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                mem[w] <= 32'h0;
            end
        end else if (a_hs && legal && is_put) begin
            for (int b = 0; b < 4; b++) begin
                if (a_mask[b]) begin
                    mem[idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    // Saturating count of denied responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_count <= 8'h00;
        end else if (a_hs && !legal && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed scoreboard bench for tl_ul_sram_responder.
module tb_tl_ul_sram_responder;

    logic        clock;
    logic        reset_n;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [2:0]  a_source;
    logic [29:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [1:0]  d_size;
    logic [2:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    logic [43:0] sb [$];
    logic [43:0] held_rsp;
    logic        held = 1'b0;

    tl_ul_sram_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_opcode  (a_opcode),
        .a_param   (a_param),
        .a_size    (a_size),
        .a_source  (a_source),
        .a_address (a_address),
        .a_mask    (a_mask),
        .a_data    (a_data),
        .a_corrupt (a_corrupt),
        .d_valid   (d_valid),
        .d_ready   (d_ready),
        .d_opcode  (d_opcode),
        .d_param   (d_param),
        .d_size    (d_size),
        .d_source  (d_source),
        .d_denied  (d_denied),
        .d_data    (d_data),
        .d_corrupt (d_corrupt),
        .err_count (err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Response fields packed as {opcode, param, size, source, denied, corrupt, data}.
    function automatic logic [43:0] rsp(input logic [2:0] op, input logic [1:0] size,
                                        input logic [2:0] src, input logic denied,
                                        input logic corrupt, input logic [31:0] data);
        return {op, 2'b00, size, src, denied, corrupt, data};
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: pop and compare every completed D beat; check stalled responses stay stable.
    always @(negedge clock) begin
        logic [43:0] cur;
        cur = {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data};
        if (reset_n && d_valid && d_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_d_beat", 64'(cur), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("d_beat", 64'(cur), 64'(sb.pop_front()));
            end
        end
        if (reset_n && d_valid && !d_ready) begin
            if (held) check("d_stable", 64'(cur), 64'(held_rsp));
            held_rsp = cur;
            held = 1'b1;
        end else begin
            held = 1'b0;
        end
    end

    task automatic drive(input logic [2:0] op, input logic [29:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [1:0] size, input logic [2:0] src,
                         input logic corrupt);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_param   = 3'd5;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_size    = size;
        a_source  = src;
        a_corrupt = corrupt;
    endtask

    task automatic wait_hs(input logic [43:0] expected);
        logic hs;
        hs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            hs = a_ready;
            @(posedge clock);
            #1;
            if (hs) break;
        end
        if (!hs) begin
            check("a_handshake_timeout", 64'd0, 64'd1);
        end else begin
            sb.push_back(expected);
            check("d_valid_latency1", 64'(d_valid), 64'd1);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [29:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [1:0] size, input logic [2:0] src,
                        input logic corrupt, input logic [43:0] expected);
        drive(op, addr, mask, data, size, src, corrupt);
        wait_hs(expected);
    endtask

    task automatic idle(input int cycles);
        a_valid = 1'b0;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        d_ready = 1'b1;
        a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0; a_source = 3'd0;
        a_address = 30'd0; a_mask = 4'd0; a_data = 32'd0; a_corrupt = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_a_ready", 64'(a_ready), 64'd1);
        check("rst_err_count", 64'(err_count), 64'd0);
        check("rst_d_fields", 64'({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data}), 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Get on reset memory, then full/partial writes and read back, back-to-back.
        send(3'd4, 30'h04, 4'hF, 32'h0, 2'd2, 3'd2, 1'b0, rsp(3'd1, 2'd2, 3'd2, 1'b0, 1'b0, 32'h0));
        send(3'd0, 30'h08, 4'hF, 32'hDEADBEEF, 2'd2, 3'd3, 1'b0, rsp(3'd0, 2'd2, 3'd3, 1'b0, 1'b0, 32'h0));
        send(3'd1, 30'h08, 4'h5, 32'h11223344, 2'd2, 3'd4, 1'b0, rsp(3'd0, 2'd2, 3'd4, 1'b0, 1'b0, 32'h0));
        send(3'd4, 30'h08, 4'hF, 32'h0, 2'd2, 3'd1, 1'b0, rsp(3'd1, 2'd2, 3'd1, 1'b0, 1'b0, 32'hDE22BE44));

        // Back-pressure: previous response held, new request stalled for 3 cycles.
        d_ready = 1'b0;
        drive(3'd4, 30'h08, 4'hF, 32'h0, 2'd1, 3'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("stall_a_ready", 64'(a_ready), 64'd0);
            check("stall_d_valid", 64'(d_valid), 64'd1);
            @(posedge clock); #1;
        end
        d_ready = 1'b1;
        wait_hs(rsp(3'd1, 2'd1, 3'd5, 1'b0, 1'b0, 32'hDE22BE44));

        // Denied requests of each kind.
        send(3'd4, 30'h40, 4'hF, 32'h0, 2'd2, 3'd6, 1'b0, rsp(3'd1, 2'd2, 3'd6, 1'b1, 1'b1, 32'h0));
        check("err_after_miss", 64'(err_count), 64'd1);
        send(3'd0, 30'h08, 4'hF, 32'hFFFFFFFF, 2'd2, 3'd7, 1'b1, rsp(3'd0, 2'd2, 3'd7, 1'b1, 1'b0, 32'h0));
        check("err_after_corrupt_put", 64'(err_count), 64'd2);
        send(3'd4, 30'h08, 4'hF, 32'h0, 2'd2, 3'd0, 1'b0, rsp(3'd1, 2'd2, 3'd0, 1'b0, 1'b0, 32'hDE22BE44));
        send(3'd4, 30'h04, 4'hF, 32'h0, 2'd3, 3'd1, 1'b0, rsp(3'd1, 2'd3, 3'd1, 1'b1, 1'b1, 32'h0));
        send(3'd2, 30'h04, 4'hF, 32'h0, 2'd2, 3'd2, 1'b0, rsp(3'd0, 2'd2, 3'd2, 1'b1, 1'b0, 32'h0));
        send(3'd0, 30'h48, 4'hF, 32'h12345678, 2'd2, 3'd3, 1'b0, rsp(3'd0, 2'd2, 3'd3, 1'b1, 1'b0, 32'h0));
        check("err_after_5_denied", 64'(err_count), 64'd5);
        send(3'd4, 30'h08, 4'hF, 32'h0, 2'd0, 3'd4, 1'b0, rsp(3'd1, 2'd0, 3'd4, 1'b0, 1'b0, 32'hDE22BE44));

        // Saturation of the denied counter.
        for (int i = 0; i < 260; i++) begin
            send(3'd4, 30'h40, 4'hF, 32'h0, 2'd2, 3'd1, 1'b0, rsp(3'd1, 2'd2, 3'd1, 1'b1, 1'b1, 32'h0));
        end
        check("err_saturated", 64'(err_count), 64'hFF);

        // Reset with a response pending.
        idle(3);
        d_ready = 1'b0;
        send(3'd4, 30'h08, 4'hF, 32'h0, 2'd2, 3'd6, 1'b0, rsp(3'd1, 2'd2, 3'd6, 1'b0, 1'b0, 32'hDE22BE44));
        a_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_d_valid", 64'(d_valid), 64'd0);
        check("async_rst_err_count", 64'(err_count), 64'd0);
        sb.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        d_ready = 1'b1;
        @(posedge clock); #1;
        send(3'd4, 30'h08, 4'hF, 32'h0, 2'd2, 3'd2, 1'b0, rsp(3'd1, 2'd2, 3'd2, 1'b0, 1'b0, 32'h0));
        send(3'd4, 30'h04, 4'hF, 32'h0, 2'd2, 3'd3, 1'b0, rsp(3'd1, 2'd2, 3'd3, 1'b0, 1'b0, 32'h0));
        idle(4);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
